// File: rtl/lsu_pkg.sv
// Shared types and data-path helpers for the load/store memory stage.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WB,
        WR,
        FLT
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only exist as B/H/W; loads additionally have the unsigned forms.
    function automatic logic illegal_f3(input logic store, input logic [2:0] funct3);
        if (store) begin
            return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end
        return (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3)
            F3_H, F3_HU: return addr[0];
            F3_W:        return addr != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ld_extract(input logic [31:0] word, input logic [2:0] funct3,
                                               input logic [1:0] addr);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{addr, 3'b000} +: 8];
        h = word[{addr[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    return {{24{b[7]}}, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_BU:   return {24'h000000, b};
            F3_HU:   return {16'h0000, h};
            default: return word;
        endcase
    endfunction

    // Only B/H stores go through the merge; a word store never reads back.
    function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [15:0] wdata,
                                             input logic [2:0] funct3, input logic [1:0] addr);
        logic [31:0] r;
        r = old;
        if (funct3 == F3_B) begin
            r[{addr, 3'b000} +: 8] = wdata[7:0];
        end else if (funct3 == F3_H) begin
            r[{addr[1], 4'b0000} +: 16] = wdata;
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction for loads and lane merge for sub-word stores (pure combinational).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [15:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_data_o
);

    assign ld_data_o = ld_extract(rd_word_i, funct3_i, addr_lo_i);
    assign st_data_o = st_merge(rd_word_i, wdata_i, funct3_i, addr_lo_i);

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one request at a time, word-wide DRAM port,
// sub-word stores done as read-modify-write.
// Optional retirement counters (ld_cnt/st_cnt/flt_cnt) when LSU_PERF_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// RD_WAIT | word address on A, waiting RD_LAT cycles for RD
// WB      | load result on A3/WD3, done pulse
// WR      | single-cycle DRAM write, done pulse
// FLT     | fault and done pulse, no memory or register activity
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [31:0] A,
    output logic [31:0] WD,
    output logic        WE,
    input  logic [31:0] RD,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        WE3,
    output logic        done,
    output logic        fault
`ifdef LSU_PERF_EN
    ,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt,
    output logic [CNT_W-1:0] flt_cnt
`endif
);

    lsu_state_t  state_q;
    logic [2:0]  cnt_q;
    logic        store_q;
    logic [2:0]  f3_q;
    logic [1:0]  addr_lo_q;
    logic [15:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] a_q, wd_q, wd3_q;
    logic [4:0]  a3_q;
    logic        we_q, we3_q, done_q, fault_q;
    logic [31:0] ld_data_d, st_data_d;

    lsu_align u_align (
        .rd_word_i (RD),
        .wdata_i   (wdata_q),
        .funct3_i  (f3_q),
        .addr_lo_i (addr_lo_q),
        .ld_data_o (ld_data_d),
        .st_data_o (st_data_d)
    );

    assign req_ready = (state_q == IDLE) && !rst;
    assign A     = a_q;
    assign WD    = wd_q;
    assign WE    = we_q;
    assign A3    = a3_q;
    assign WD3   = wd3_q;
    assign WE3   = we3_q;
    assign done  = done_q;
    assign fault = fault_q;

    // Request sequencing; all outputs are registered and pulses last one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            store_q   <= 1'b0;
            f3_q      <= '0;
            addr_lo_q <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            wd_q      <= '0;
            a3_q      <= '0;
            wd3_q     <= '0;
            we_q      <= 1'b0;
            we3_q     <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            we_q    <= 1'b0;
            we3_q   <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        store_q   <= req_store;
                        f3_q      <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        rd_q      <= req_rd;
                        cnt_q     <= 3'(RD_LAT - 1);
                        if (illegal_f3(req_store, req_funct3) || misaligned(req_funct3, req_addr[1:0])) begin
                            state_q <= FLT;
                            fault_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (req_store && req_funct3 == F3_W) begin
                            state_q <= WR;
                            a_q     <= {req_addr[31:2], 2'b00};
                            wd_q    <= req_wdata;
                            we_q    <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RD_WAIT;
                            a_q     <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        done_q <= 1'b1;
                        if (store_q) begin
                            state_q <= WR;
                            wd_q    <= st_data_d;
                            we_q    <= 1'b1;
                        end else begin
                            state_q <= WB;
                            a3_q    <= rd_q;
                            wd3_q   <= ld_data_d;
                            we3_q   <= (rd_q != 5'd0);
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                WB, WR, FLT: state_q <= IDLE;
                default:     state_q <= IDLE;
            endcase
        end
    end

`ifdef LSU_PERF_EN
    logic [CNT_W-1:0] ld_cnt_q, st_cnt_q, flt_cnt_q;

    assign ld_cnt  = ld_cnt_q;
    assign st_cnt  = st_cnt_q;
    assign flt_cnt = flt_cnt_q;

    // Retirement counters, each saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt_q  <= '0;
            st_cnt_q  <= '0;
            flt_cnt_q <= '0;
        end else begin
            if (state_q == WB && ld_cnt_q != '1)   ld_cnt_q  <= ld_cnt_q + CNT_W'(1);
            if (state_q == WR && st_cnt_q != '1)   st_cnt_q  <= st_cnt_q + CNT_W'(1);
            if (state_q == FLT && flt_cnt_q != '1) flt_cnt_q <= flt_cnt_q + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store stage between the execute stage and the DRAM/register-file ports.
- Accepts one memory request at a time and drives word-wide DRAM accesses on A/WD/WE/RD.
- Sub-word stores are done as read-modify-write because the DRAM port has no byte enables.
- Load results are extracted, extended, and written back through A3/WD3/WE3.

Parameters:
- RD_LAT, 1, DRAM read latency in cycles (1..7); RD is valid in the RD_LAT-th cycle that A is held.
- CNT_W, 16, counter width (used only with LSU_PERF_EN).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request valid
- req_ready  out  1  stage idle and able to accept
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low bits used for B/H)
- req_rd  in  5  load destination register
- A  out  32  DRAM word address (byte address with [1:0]=00)
- WD  out  32  DRAM write data
- WE  out  1  DRAM write enable
- RD  in  32  DRAM read data
- A3  out  5  register-file write address
- WD3  out  32  register-file write data
- WE3  out  1  register-file write enable
- done  out  1  one-cycle pulse when a request retires (including faults)
- fault  out  1  one-cycle pulse on misaligned address or illegal funct3

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; A, WD, A3, WD3=0; WE, WE3, done, fault=0.
- req_ready = (state==IDLE) && !rst.
- A request is accepted in cycle T when req_valid && req_ready; all request fields are latched.
- States: IDLE, RD_WAIT, WB, WR, FLT.
- Decode at accept:
  - Illegal funct3 (loads: 011/110/111; stores: anything other than 000/001/010) -> FLT.
  - Misalignment -> FLT: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Load -> RD_WAIT.
  - SW -> WR.
  - SB/SH -> RD_WAIT (RMW flag set).
- FLT (cycle T+1):
  - fault=1, done=1.
  - No DRAM or register-file activity; WE and WE3 stay 0.
  - Next state IDLE.
- RD_WAIT:
  - A = {addr[31:2],2'b00}, WE=0, held for RD_LAT cycles.
  - RD is sampled on the last of those cycles.
  - Next state: WB for loads, WR for RMW stores.
- WB (cycle T+RD_LAT+1):
  - Lane = addr[1:0] for bytes, addr[1] for halves.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - A3=rd, WD3=result, done=1.
  - WE3=1 unless rd==0; for rd==0, WE3=0 but done still pulses.
- WR:
  - A = word address, WE=1 for exactly one cycle, done=1.
  - WD = req_wdata for SW.
  - For SB/SH, WD = sampled RD with the selected lane(s) replaced by wdata[7:0]/[15:0].
- Latencies (accept to done): SW 1; load RD_LAT+1; SB/SH RD_LAT+1; fault 1.
- Output hold: A3/WD3 hold their value after WB; A/WD hold after WR. WE, WE3, done, fault are single-cycle.
- Reset mid-operation (including during an RMW read) aborts with no write. WE stays low, and req_ready=1 in the first cycle after rst falls.
- While busy, req_valid is ignored; the upstream stage holds its request until req_ready.
- A new request can be accepted in the cycle after done.

Optional Feature:
- LSU_PERF_EN defined adds outputs ld_cnt, st_cnt, flt_cnt (each CNT_W bits).
  - They count retired loads, retired stores, and faults.
  - Saturating at all-ones; reset to 0.
- LSU_PERF_EN undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- lsu_pkg:
  - state enum lsu_state_t {IDLE, RD_WAIT, WB, WR, FLT}.
  - funct3 constants F3_B/H/W/BU/HU.
  - Functions: misaligned(funct3, addr), ld_extract(word, funct3, addr), st_merge(old, wdata, funct3, addr).
- One sub-module lsu_align (combinational): instantiates ld_extract/st_merge and keeps the data-path logic out of the FSM.

Test Plan:
- LW 0x100, rd=5, RD=0xDEADBEEF, RD_LAT=1 -> A=0x100 at T+1; WE3=1, A3=5, WD3=0xDEADBEEF at T+2; done at T+2.
- LB 0x103, RD=0x80112233 -> WD3=0xFFFFFF80. LBU at the same address -> WD3=0x00000080. LH 0x102 -> 0xFFFF8011.
- SH 0x202, wdata=0x0000ABCD, old RD=0x11223344 -> one WE pulse with A=0x200, WD=0xABCD3344. SW 0x204 with data 0x12345678 -> WE at T+1, WD=0x12345678.
- LW 0x101 or SH 0x203 -> fault=1, done=1 at T+1; WE and WE3 never assert; req_ready=1 at T+2.
- SB 0x300 with rst pulsed during RD_WAIT (RD_LAT=3) -> WE never asserts; all outputs 0; req_ready=1 in the cycle after rst falls.
- LW to rd=0 -> done=1, WE3=0. With LSU_PERF_EN: 2 loads, 1 store, 1 fault -> ld_cnt=2, st_cnt=1, flt_cnt=1.
